// File: rtl/demux14_pkg.sv
// Shared constants and types for the demux14_stream four-way stream demultiplexer.
package demux14_pkg;
    localparam int WIDTH  = 16;
    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;
    localparam int CNT_W  = 8;

    typedef logic [CH_W-1:0] ch_idx_t;
endpackage

// File: rtl/demux14_stream_if.sv
// Stream bus of demux14_stream: one valid/ready input, four valid/ready output
// channels, plus round-robin pointer and per-channel delivered-word counters.
interface demux14_stream_if;
    import demux14_pkg::*;

    logic [WIDTH-1:0]        in_data;
    ch_idx_t                 in_sel;
    logic                    in_auto;
    logic                    in_valid;
    logic                    in_ready;
    logic [NUM_CH*WIDTH-1:0] out_data;
    logic [NUM_CH-1:0]       out_valid;
    logic [NUM_CH-1:0]       out_ready;
    ch_idx_t                 rr_ptr;
    logic [NUM_CH*CNT_W-1:0] out_cnt;

    modport master (
        output in_data, in_sel, in_auto, in_valid, out_ready,
        input  in_ready, out_data, out_valid, rr_ptr, out_cnt
    );

    modport slave (
        input  in_data, in_sel, in_auto, in_valid, out_ready,
        output in_ready, out_data, out_valid, rr_ptr, out_cnt
    );
endinterface

// File: rtl/demux14_slot.sv
// One-entry holding register for a single output channel; a load wins over a
// same-cycle drain so the slot can be emptied and refilled in one cycle.
module demux14_slot
    import demux14_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             drain,
    input  logic [WIDTH-1:0] load_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);
    // NOTE: the data register is reset as well, because out_data must read zero
    // after reset; deep storage arrays would normally be left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            // NOTE: non-blocking assignments keep every register sampling
            // pre-edge values, independent of statement order.
            valid <= 1'b1;
            data  <= load_data;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/demux14_stream.sv
// Four-way stream demultiplexer with select or round-robin routing and one
// holding slot per channel. Optional per-channel delivered-word counters are
// built when DEMUX14_COUNT_EN is defined; otherwise out_cnt reads zero.
module demux14_stream
    import demux14_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    demux14_stream_if.slave bus
);
    ch_idx_t                 target;
    ch_idx_t                 rr_q;
    logic                    in_ready;
    logic                    accept;
    logic [NUM_CH-1:0]       free;
    logic [NUM_CH-1:0]       load;
    logic [NUM_CH-1:0]       drain;
    logic [NUM_CH-1:0]       slot_valid;
    logic [WIDTH-1:0]        slot_data [NUM_CH];
    logic [NUM_CH*WIDTH-1:0] out_data_w;

    assign target   = bus.in_auto ? rr_q : bus.in_sel;
    // A full slot is still free when its consumer drains it this cycle.
    assign free     = ~slot_valid | bus.out_ready;
    assign in_ready = free[target];
    assign accept   = bus.in_valid & in_ready;
    assign drain    = slot_valid & bus.out_ready;

    always_comb begin
        // NOTE: default first so no path leaves load unassigned (no latch).
        load = '0;
        if (accept) load[target] = 1'b1;
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        demux14_slot u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load[k]),
            .drain     (drain[k]),
            .load_data (bus.in_data),
            .valid     (slot_valid[k]),
            .data      (slot_data[k])
        );
    end

    always_comb begin
        out_data_w = '0;
        for (int k = 0; k < NUM_CH; k++) out_data_w[WIDTH*k +: WIDTH] = slot_data[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     rr_q <= '0;
        else if (accept && bus.in_auto) rr_q <= ch_idx_t'(rr_q + 2'd1);
    end

`ifdef DEMUX14_COUNT_EN
    logic [CNT_W-1:0] cnt_q [NUM_CH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++)
                if (drain[k]) cnt_q[k] <= cnt_q[k] + 1'b1;
        end
    end

    always_comb begin
        bus.out_cnt = '0;
        for (int k = 0; k < NUM_CH; k++) bus.out_cnt[CNT_W*k +: CNT_W] = cnt_q[k];
    end
`else
    assign bus.out_cnt = '0;
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = slot_valid;
    assign bus.out_data  = out_data_w;
    assign bus.rr_ptr    = rr_q;
endmodule
